// File: rtl/mole_field.sv
// rtl/mole_field.sv - whack-a-mole playfield controller with per-hole lifetimes, round timer and scoring
//
// Purpose: N_MOLES holes, each with its own age counter. A game FSM (IDLE/ARM/PLAY/OVER)
// sweeps the LEDs while idle, arms a round on start, scores switch toggles against live
// moles by reaction time, and freezes the results once the round timer runs out.
//
// Optional feature macro: MOLE_MISS_PENALTY_EN
//   defined   - toggles on empty holes count as misses and deduct PENALTY points each
//   undefined - misses are ignored and the misses output is tied to 0
//
// Ports:
//   clk        in   system clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse, begins a round from IDLE or OVER
//   tick       in   game-time strobe
//   random     in   [N_MOLES] spawn mask, sampled on tick
//   life       in   [LIFE_W] mole lifetime in ticks, sampled in ARM (0 means 1)
//   round_len  in   [ROUND_W] round length in ticks, sampled in ARM (0 means 1)
//   switch     in   [N_MOLES] synchronised switch levels
//   moles      out  [N_MOLES] LED drive
//   score      out  [SCORE_W] saturating score
//   hits       out  [8] saturating hit count
//   misses     out  [8] saturating miss count
//   escapes    out  [8] saturating escape count
//   done       out  high while the round is over
module mole_field #(
    parameter int unsigned N_MOLES = 10,
    parameter int unsigned LIFE_W  = 8,
    parameter int unsigned ROUND_W = 16,
    parameter int unsigned SCORE_W = 24,
    parameter int unsigned PENALTY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               tick,
    input  logic [N_MOLES-1:0] random,
    input  logic [LIFE_W-1:0]  life,
    input  logic [ROUND_W-1:0] round_len,
    input  logic [N_MOLES-1:0] switch,
    output logic [N_MOLES-1:0] moles,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         hits,
    output logic [7:0]         misses,
    output logic [7:0]         escapes,
    output logic               done
);

    localparam int unsigned PTR_W = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
    localparam int unsigned CNT_W = $clog2(N_MOLES + 1);
    localparam int unsigned SUM_W = LIFE_W + $clog2(N_MOLES) + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(N_MOLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic in_idle, in_arm, in_play;
    logic round_end;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               dir_up_q, dir_up_d;
    logic [N_MOLES-1:0] moles_q, moles_d;
    logic [LIFE_W-1:0]  age_q [N_MOLES];
    logic [LIFE_W-1:0]  age_d [N_MOLES];
    logic [N_MOLES-1:0] sw_buf_q, sw_buf_d;
    logic [LIFE_W-1:0]  life_q, life_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         hits_q, hits_d;
    logic [7:0]         esc_q, esc_d;

    logic [N_MOLES-1:0] toggle, hit_v;
    logic [SUM_W-1:0]   pts_sum;
    logic [CNT_W-1:0]   hit_cnt, esc_cnt;
    logic [LIFE_W-1:0]  age_inc;
    logic [SCORE_W:0]   score_wide;
    logic [SCORE_W-1:0] score_hit;

`ifdef MOLE_MISS_PENALTY_EN
    logic [N_MOLES-1:0] miss_v;
    logic [CNT_W-1:0]   miss_cnt;
    logic [SCORE_W:0]   pen_amt;
    logic [7:0]         misses_q, misses_d;
`endif

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [CNT_W-1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Round ends on the tick that consumes the last remaining round tick.
    assign round_end = tick && (round_q == ROUND_W'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_ARM;
            S_ARM:   state_d = S_PLAY;
            S_PLAY:  if (round_end) state_d = S_OVER;
            S_OVER:  if (start) state_d = S_ARM;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_idle = (state_q == S_IDLE);
        in_arm  = (state_q == S_ARM);
        in_play = (state_q == S_PLAY);
        done    = (state_q == S_OVER);
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        ptr_d      = ptr_q;
        dir_up_d   = dir_up_q;
        moles_d    = moles_q;
        age_d      = age_q;
        sw_buf_d   = sw_buf_q;
        life_d     = life_q;
        round_d    = round_q;
        score_d    = score_q;
        hits_d     = hits_q;
        esc_d      = esc_q;
        toggle     = '0;
        hit_v      = '0;
        pts_sum    = '0;
        hit_cnt    = '0;
        esc_cnt    = '0;
        age_inc    = '0;
        score_wide = '0;
        score_hit  = '0;
`ifdef MOLE_MISS_PENALTY_EN
        miss_v     = '0;
        miss_cnt   = '0;
        pen_amt    = '0;
        misses_d   = misses_q;
`endif

        if (in_idle) begin
            // Bouncing sweep: reverse at either end instead of wrapping.
            if (tick) begin
                if (dir_up_q) begin
                    if (ptr_q == PTR_LAST) begin
                        ptr_d    = ptr_q - PTR_W'(1);
                        dir_up_d = 1'b0;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end else begin
                    if (ptr_q == '0) begin
                        ptr_d    = ptr_q + PTR_W'(1);
                        dir_up_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q - PTR_W'(1);
                    end
                end
            end
            moles_d = N_MOLES'(1) << ptr_d;
        end else if (in_arm) begin
            sw_buf_d = switch;
            moles_d  = '0;
            for (int i = 0; i < N_MOLES; i++) begin
                age_d[i] = '0;
            end
            score_d  = '0;
            hits_d   = '0;
            esc_d    = '0;
            life_d   = (life == '0) ? LIFE_W'(1) : life;
            round_d  = (round_len == '0) ? ROUND_W'(1) : round_len;
`ifdef MOLE_MISS_PENALTY_EN
            misses_d = '0;
`endif
        end else if (in_play) begin
            sw_buf_d = switch;
            toggle   = switch ^ sw_buf_q;
            hit_v    = toggle & moles_q;
`ifdef MOLE_MISS_PENALTY_EN
            miss_v   = toggle & ~moles_q;
`endif
            // Every decision uses moles_q (state at cycle start), so a hit
            // outranks expiry and a hole hit this cycle cannot respawn.
            for (int i = 0; i < N_MOLES; i++) begin
                if (hit_v[i]) begin
                    moles_d[i] = 1'b0;
                    pts_sum    = pts_sum + SUM_W'(life_q - age_q[i]);
                    hit_cnt    = hit_cnt + CNT_W'(1);
                end else if (tick && moles_q[i]) begin
                    age_inc  = age_q[i] + LIFE_W'(1);
                    age_d[i] = age_inc;
                    if (age_inc == life_q) begin
                        moles_d[i] = 1'b0;
                        esc_cnt    = esc_cnt + CNT_W'(1);
                    end
                end else if (tick && random[i]) begin
                    moles_d[i] = 1'b1;
                    age_d[i]   = '0;
                end
`ifdef MOLE_MISS_PENALTY_EN
                if (miss_v[i]) begin
                    miss_cnt = miss_cnt + CNT_W'(1);
                end
`endif
            end

            score_wide = {1'b0, score_q} + (SCORE_W + 1)'(pts_sum);
            score_hit  = score_wide[SCORE_W] ? SCORE_MAX : score_wide[SCORE_W-1:0];
            score_d    = score_hit;
`ifdef MOLE_MISS_PENALTY_EN
            // Penalty comes after this cycle's hit points, floored at zero.
            pen_amt  = (SCORE_W + 1)'(PENALTY) * (SCORE_W + 1)'(miss_cnt);
            score_d  = ({1'b0, score_hit} < pen_amt) ? '0 : (score_hit - pen_amt[SCORE_W-1:0]);
            misses_d = sat_add8(misses_q, miss_cnt);
`endif
            hits_d = sat_add8(hits_q, hit_cnt);
            esc_d  = sat_add8(esc_q, esc_cnt);

            if (tick) begin
                round_d = round_q - ROUND_W'(1);
                // Moles still up when time runs out vanish without counting as escapes.
                if (round_end) begin
                    moles_d = '0;
                end
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            dir_up_q <= 1'b1;
            moles_q  <= '0;
            for (int i = 0; i < N_MOLES; i++) begin
                age_q[i] <= '0;
            end
            sw_buf_q <= '0;
            life_q   <= LIFE_W'(1);
            round_q  <= ROUND_W'(1);
            score_q  <= '0;
            hits_q   <= '0;
            esc_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            dir_up_q <= dir_up_d;
            moles_q  <= moles_d;
            age_q    <= age_d;
            sw_buf_q <= sw_buf_d;
            life_q   <= life_d;
            round_q  <= round_d;
            score_q  <= score_d;
            hits_q   <= hits_d;
            esc_q    <= esc_d;
        end
    end

`ifdef MOLE_MISS_PENALTY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misses_q <= '0;
        end else begin
            misses_q <= misses_d;
        end
    end

    assign misses = misses_q;
`else
    // PENALTY has no effect when miss handling is not built.
    logic unused_penalty;
    assign unused_penalty = (PENALTY != 0);
    assign misses         = '0;
`endif

    assign moles   = moles_q;
    assign score   = score_q;
    assign hits    = hits_q;
    assign escapes = esc_q;

endmodule

// File: tb/tb_mole_field.sv
// tb/tb_mole_field.sv - randomized self-checking bench for mole_field against a rule-level game model
`timescale 1ns/1ps
module tb_mole_field;

    localparam int N   = 10;
    localparam int LW  = 8;
    localparam int RW  = 16;
    localparam int SW  = 24;
    localparam int PEN = 4;
    localparam longint SCORE_MAX = (64'd1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          tick = 1'b0;
    logic [N-1:0]  random_i = '0;
    logic [LW-1:0] life_i = 8'd5;
    logic [RW-1:0] round_len_i = 16'd10;
    logic [N-1:0]  switch_i = '0;
    logic [N-1:0]  moles;
    logic [SW-1:0] score;
    logic [7:0]    hits, misses, escapes;
    logic          done;

    mole_field #(
        .N_MOLES(N), .LIFE_W(LW), .ROUND_W(RW), .SCORE_W(SW), .PENALTY(PEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .random(random_i),
        .life(life_i), .round_len(round_len_i), .switch(switch_i),
        .moles(moles), .score(score), .hits(hits), .misses(misses),
        .escapes(escapes), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural game model ----------------
    typedef enum int {PH_IDLE, PH_ARM, PH_PLAY, PH_OVER} phase_t;
    phase_t       ph;
    int           pos;
    bit           up;
    bit           alive [N];
    int           age [N];
    int           m_life, m_round, m_hits, m_misses, m_esc;
    longint       m_score;
    logic [N-1:0] m_buf, m_moles;

    task automatic model_reset();
        ph = PH_IDLE; pos = 0; up = 1'b1;
        for (int i = 0; i < N; i++) begin alive[i] = 1'b0; age[i] = 0; end
        m_life = 1; m_round = 1; m_hits = 0; m_misses = 0; m_esc = 0;
        m_score = 0; m_buf = '0; m_moles = '0;
    endtask

    // Applies one clock of game rules to the inputs currently driven.
    task automatic model_step();
        int pts, nhit, nmiss, nesc;
        bit tg, was;
        pts = 0; nhit = 0; nmiss = 0; nesc = 0;
        case (ph)
            PH_IDLE: begin
                if (tick) begin
                    if (up) begin
                        if (pos == N - 1) begin up = 1'b0; pos = pos - 1; end
                        else pos = pos + 1;
                    end else begin
                        if (pos == 0) begin up = 1'b1; pos = pos + 1; end
                        else pos = pos - 1;
                    end
                end
                m_moles = '0;
                m_moles[pos] = 1'b1;
                if (start) ph = PH_ARM;
            end
            PH_ARM: begin
                m_buf = switch_i;
                for (int i = 0; i < N; i++) begin alive[i] = 1'b0; age[i] = 0; end
                m_score = 0; m_hits = 0; m_misses = 0; m_esc = 0;
                m_life  = (life_i == 0) ? 1 : int'(life_i);
                m_round = (round_len_i == 0) ? 1 : int'(round_len_i);
                m_moles = '0;
                ph = PH_PLAY;
            end
            PH_PLAY: begin
                for (int i = 0; i < N; i++) begin
                    tg  = switch_i[i] ^ m_buf[i];
                    was = alive[i];
                    if (tg && was) begin
                        pts = pts + (m_life - age[i]);
                        nhit++;
                        alive[i] = 1'b0;
                    end else begin
                        if (tg) nmiss++;
                        if (tick && was) begin
                            age[i] = age[i] + 1;
                            if (age[i] == m_life) begin alive[i] = 1'b0; nesc++; end
                        end else if (tick && random_i[i]) begin
                            alive[i] = 1'b1; age[i] = 0;
                        end
                    end
                end
                m_buf   = switch_i;
                m_score = m_score + pts;
                if (m_score > SCORE_MAX) m_score = SCORE_MAX;
`ifdef MOLE_MISS_PENALTY_EN
                m_score = m_score - PEN * nmiss;
                if (m_score < 0) m_score = 0;
                m_misses = (m_misses + nmiss > 255) ? 255 : m_misses + nmiss;
`endif
                m_hits = (m_hits + nhit > 255) ? 255 : m_hits + nhit;
                m_esc  = (m_esc + nesc > 255) ? 255 : m_esc + nesc;
                if (tick) begin
                    if (m_round == 1) begin
                        ph = PH_OVER;
                        for (int i = 0; i < N; i++) alive[i] = 1'b0;
                    end
                    m_round = m_round - 1;
                end
                m_moles = '0;
                for (int i = 0; i < N; i++) m_moles[i] = alive[i];
            end
            default: begin
                m_moles = '0;
                if (start) ph = PH_ARM;
            end
        endcase
    endtask

    task automatic clk_step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic start_round(input int lf, input int rl);
        life_i = LW'(lf); round_len_i = RW'(rl);
        start = 1'b1; clk_step();
        start = 1'b0; clk_step();
    endtask

    task automatic tick_step(input logic [N-1:0] mask);
        random_i = mask; tick = 1'b1; clk_step();
        random_i = '0;   tick = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        checks++; if (moles !== '0)  begin errors++; $display("FAIL reset_moles got %0h want 0", moles); end
        checks++; if (score !== '0)  begin errors++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if (hits !== 8'd0 || misses !== 8'd0 || escapes !== 8'd0)
            begin errors++; $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", hits, misses, escapes); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_sweep();
        logic [N-1:0] exp_seq [12];
        exp_seq = '{10'd1, 10'd2, 10'd4, 10'd8, 10'd16, 10'd32, 10'd64, 10'd128,
                    10'd256, 10'd512, 10'd256, 10'd128};
        clk_step();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (moles !== exp_seq[k]) begin
                errors++; $display("FAIL sweep_%0d got %0h want %0h", k, moles, exp_seq[k]);
            end
            tick = 1'b1; clk_step(); tick = 1'b0; clk_step();
        end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (moles !== '0) begin errors++; $display("FAIL async_reset_moles got %0h want 0", moles); end
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_hit();
        do_reset();
        start_round(5, 100);
        tick_step(10'h001);
        checks++; if (moles[0] !== 1'b1) begin errors++; $display("FAIL hit_spawn got %0b want 1", moles[0]); end
        repeat (2) begin tick_step('0); clk_step(); end
        switch_i[0] = ~switch_i[0];
        clk_step();
        checks++; if (moles[0] !== 1'b0) begin errors++; $display("FAIL hit_clear got %0b want 0", moles[0]); end
        checks++; if (score !== SW'(3))  begin errors++; $display("FAIL hit_score got %0d want 3", score); end
        checks++; if (hits !== 8'd1)     begin errors++; $display("FAIL hit_count got %0d want 1", hits); end
    endtask

    task automatic test_escape();
        tick_step(10'h001);
        for (int t = 1; t <= 5; t++) begin
            tick_step('0);
            checks++;
            if (moles[0] !== ((t < 5) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL escape_tick%0d got %0b want %0b", t, moles[0], (t < 5));
            end
        end
        checks++; if (escapes !== 8'd1) begin errors++; $display("FAIL escape_count got %0d want 1", escapes); end
        checks++; if (score !== SW'(3)) begin errors++; $display("FAIL escape_score got %0d want 3", score); end
    endtask

    task automatic test_multi_hit();
        do_reset();
        start_round(8, 100);
        tick_step(10'h009);
        checks++; if (moles !== 10'h009) begin errors++; $display("FAIL multi_spawn got %0h want 9", moles); end
        switch_i = switch_i ^ 10'h009;
        clk_step();
        checks++; if (score !== SW'(16)) begin errors++; $display("FAIL multi_score got %0d want 16", score); end
        checks++; if (hits !== 8'd2)     begin errors++; $display("FAIL multi_hits got %0d want 2", hits); end
    endtask

    task automatic test_penalty();
        logic [SW-1:0] exp_score;
        logic [7:0]    exp_miss;
        do_reset();
        start_round(5, 100);
        tick_step(10'h001);
        repeat (3) tick_step('0);
        switch_i[0] = ~switch_i[0];
        clk_step();
        checks++; if (score !== SW'(2)) begin errors++; $display("FAIL pen_pre_score got %0d want 2", score); end
`ifdef MOLE_MISS_PENALTY_EN
        exp_score = '0;    exp_miss = 8'd1;
`else
        exp_score = SW'(2); exp_miss = 8'd0;
`endif
        switch_i[5] = ~switch_i[5];
        clk_step();
        checks++; if (score !== exp_score) begin errors++; $display("FAIL pen_score got %0d want %0d", score, exp_score); end
        checks++; if (misses !== exp_miss) begin errors++; $display("FAIL pen_misses got %0d want %0d", misses, exp_miss); end
    endtask

    task automatic test_round_end();
        do_reset();
        start_round(5, 3);
        tick_step(10'h003);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL round_done_t1 got %0b want 0", done); end
        tick_step('0);
        switch_i[0] = ~switch_i[0];
        clk_step();
        checks++; if (score !== SW'(4)) begin errors++; $display("FAIL round_score got %0d want 4", score); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL round_done_t2 got %0b want 0", done); end
        tick_step('0);
        checks++; if (done !== 1'b1)    begin errors++; $display("FAIL round_done_t3 got %0b want 1", done); end
        checks++; if (moles !== '0)     begin errors++; $display("FAIL round_moles got %0h want 0", moles); end
        checks++; if (escapes !== 8'd0) begin errors++; $display("FAIL round_esc got %0d want 0", escapes); end
        repeat (4) begin switch_i = ~switch_i; tick_step(10'h3FF); end
        checks++; if (score !== SW'(4) || done !== 1'b1)
            begin errors++; $display("FAIL over_hold got score %0d done %0b want 4 1", score, done); end
        start_round(5, 3);
        checks++; if (score !== '0 || hits !== 8'd0 || done !== 1'b0)
            begin errors++; $display("FAIL restart_clear got %0d/%0d/%0b want 0/0/0", score, hits, done); end
        tick_step(10'h004);
        checks++; if (moles !== 10'h004) begin errors++; $display("FAIL restart_play got %0h want 4", moles); end
    endtask

    task automatic test_saturation();
        do_reset();
        start_round(2, 1000);
        for (int k = 0; k < 30; k++) begin
            tick_step(10'h3FF);
            switch_i = ~switch_i;
            clk_step();
        end
        checks++; if (hits !== 8'd255)    begin errors++; $display("FAIL sat_hits got %0d want 255", hits); end
        checks++; if (score !== SW'(600)) begin errors++; $display("FAIL sat_score got %0d want 600", score); end
    endtask

    task automatic test_random();
        int idx;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            start       = ($urandom_range(0, 39) == 0);
            tick        = ($urandom_range(0, 2) == 0);
            random_i    = N'($urandom & $urandom);
            life_i      = LW'($urandom_range(0, 6));
            round_len_i = RW'($urandom_range(0, 30));
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, N - 1);
                switch_i[idx] = ~switch_i[idx];
            end
            clk_step();
            checks++; if (moles !== m_moles)
                begin errors++; $display("FAIL rnd_moles c%0d got %0h want %0h", c, moles, m_moles); end
            checks++; if (score !== SW'(m_score))
                begin errors++; $display("FAIL rnd_score c%0d got %0d want %0d", c, score, m_score); end
            checks++; if (hits !== 8'(m_hits) || escapes !== 8'(m_esc) || misses !== 8'(m_misses))
                begin errors++; $display("FAIL rnd_stats c%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                                         c, hits, escapes, misses, m_hits, m_esc, m_misses); end
            checks++; if (done !== (ph == PH_OVER))
                begin errors++; $display("FAIL rnd_done c%0d got %0b want %0b", c, done, (ph == PH_OVER)); end
        end
        start = 1'b0; tick = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sweep();
        test_hit();
        test_escape();
        test_multi_hit();
        test_penalty();
        test_round_end();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
